tt_au_booth_multi_hhrb98: RTL and testbench
===========================================

// Module: tt_au_booth_multi_hhrb98
// PURPOSE
//  Sequential radix-2 Booth multiplier tile for the TinyTapeout harness.
//  - Two 4-bit two's-complement operands: X on dedicated inputs, Y on the uio input bus.
//  - One Booth iteration per clock; latched 8-bit signed product on Z.
//  - Standalone user project; no other on-chip clients.
// PARAMETERS
//  N  4  operand width in bits; product is 2*N = 8 bits and must fit Z exactly
// PORTS
//  clk      in   1  single clock; all state on rising edge
//  rst_n    in   1  reset, asynchronous, ACTIVE-HIGH (asserted when 1; port name kept for harness)
//  ena      in   1  tile enable; 0 freezes all state
//  X        in   8  [3:0] multiplicand M (signed), [4] start, [7:5] ignored
//  Y        in   8  [3:0] multiplier Q (signed), [7:4] ignored (uio input path)
//  Z        out  8  signed product, registered
//  uio_out  out  8  {6'b0, done, busy}
//  uio_oe   out  8  constant 8'h00; all uio pins are inputs
// BEHAVIOUR
//  - Reset (async, rst_n=1): state=IDLE, A=0, Q=0, q_m1=0, cnt=0, Z=0, busy=0, done=0, start_q=0.
//  - When ena=0, no register changes; reset still acts.
//  - start_q registers X[4] each enabled cycle; a start event is X[4]=1 && start_q=0 (rising edge).
//  - FSM states:
//    - IDLE: on a start event, load M=X[3:0], Q=Y[3:0], A=0, q_m1=0, cnt=0, clear done -> RUN.
//    - RUN: one iteration per cycle, then cnt++.
//      - Iteration: {Q0,q_m1}=10 -> A=A-M; 01 -> A=A+M; 00/11 -> A unchanged.
//      - Then arithmetic right shift of {A,Q,q_m1} by one.
//      - After the N-th iteration (cnt==N-1) -> DONE.
//    - DONE: Z <= {A,Q}, done<=1 -> IDLE.
//  - busy=1 in RUN and DONE.
//  - done stays 1 until the next accepted start; Z holds its value until the next DONE.
//  - Latency: start edge sampled at edge 0; Z valid after edge N+1 (5 cycles).
//  - Start events while busy are ignored (not queued); operand changes during RUN have no effect.
//  - Arithmetic: A is N+1 bits wide so A-M cannot overflow (M=-8 case).
//    Product range -56..64 fits 8-bit signed.
//  - Reset mid-operation aborts immediately; all outputs return to reset values.
// CONFIGURATION
//  BOOTH_CLR_ON_START_EN
//   - Defined: Z clears to 8'h00 on the same edge a start is accepted.
//   - Undefined: Z keeps the previous product until DONE overwrites it.
// STRUCTURE
//  - Package tt_au_booth_pkg holds:
//    - localparam N;
//    - state enum {IDLE,RUN,DONE};
//    - typedefs for operand (N bits), accumulator (N+1 bits) and product (2N bits).
//  - One sub-module, booth_step: combinational single iteration.
//    - Inputs: A, Q, q_m1, M.
//    - Outputs: next A, Q, q_m1 (add/sub plus arithmetic shift).
//  - Top holds FSM, counter, start edge detect, output register.
// TESTING
//  - X=0x03, Y=0x05, pulse X[4] -> after 5 cycles Z=0x0F, done=1, busy=0.
//  - X[3:0]=0x8 (-8), Y=0x8 (-8) -> Z=0x40 (64).
//  - X[3:0]=0xD (-3), Y=0x7 -> Z=0xEB (-21); then X[3:0]=0x7, Y=0x8 -> Z=0xC8 (-56).
//  - Hold X[4]=1 for 10 cycles -> exactly one computation.
//    Re-pulse X[4] during RUN -> ignored, Z unchanged until DONE.
//  - Assert rst_n=1 mid-RUN -> Z=0x00, uio_out=0x00 immediately.
//    Then ena=0 with a start pulse -> no activity; uio_oe=0x00 always.

Source files
------------

// File: rtl/tt_au_booth_pkg.sv
// rtl/tt_au_booth_pkg.sv - shared types and constants for the Booth multiplier tile
// Purpose: operand width, FSM state encoding and datapath typedefs used by
//          tt_au_booth_multi_hhrb98 and booth_step.
// Ports:   none (package).
package tt_au_booth_pkg;

  localparam int N     = 4;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [N-1:0]   operand_t;
  typedef logic signed [N:0]     acc_t;
  typedef logic signed [2*N-1:0] product_t;

endpackage

// File: rtl/tt_au_booth_multi_hhrb98_booth_step.sv
// rtl/tt_au_booth_multi_hhrb98_booth_step.sv - one combinational radix-2 Booth iteration
// Purpose: conditional add/subtract of the multiplicand into the accumulator,
//          followed by an arithmetic right shift of {A, Q, q_m1}.
// Ports:
//   a_in    in  N+1  accumulator A
//   q_in    in  N    multiplier register Q
//   q_m1_in in  1    Booth guard bit
//   m_in    in  N    multiplicand M (signed)
//   a_out   out N+1  next A
//   q_out   out N    next Q
//   q_m1_out out 1   next guard bit
module booth_step
  import tt_au_booth_pkg::*;
(
  input  acc_t     a_in,
  input  operand_t q_in,
  input  logic     q_m1_in,
  input  operand_t m_in,
  output acc_t     a_out,
  output operand_t q_out,
  output logic     q_m1_out
);

  acc_t m_ext;
  acc_t sum;

  // A is one bit wider than M, so sign-extending M keeps A-M exact for M=-8.
  assign m_ext = {m_in[N-1], m_in};

  always_comb begin
    sum = a_in;
    case ({q_in[0], q_m1_in})
      2'b10:   sum = a_in - m_ext;
      2'b01:   sum = a_in + m_ext;
      default: sum = a_in;
    endcase
  end

  // Arithmetic right shift of the concatenation {sum, Q, q_m1}.
  assign a_out    = {sum[N], sum[N:1]};
  assign q_out    = {sum[0], q_in[N-1:1]};
  assign q_m1_out = q_in[0];

endmodule

// File: rtl/tt_au_booth_multi_hhrb98.sv
// rtl/tt_au_booth_multi_hhrb98.sv - sequential radix-2 Booth multiplier tile
// Purpose: multiplies two signed 4-bit operands, one Booth iteration per clock,
//          and latches the signed 8-bit product on Z.
// Optional feature macro: BOOTH_CLR_ON_START_EN (clear Z when a start is accepted).
// Ports:
//   clk     in  1  clock, rising edge
//   rst_n   in  1  asynchronous reset, active high (name kept for the harness)
//   ena     in  1  tile enable; 0 freezes all state
//   X       in  8  [3:0] multiplicand, [4] start, [7:5] unused
//   Y       in  8  [3:0] multiplier, [7:4] unused
//   Z       out 8  registered signed product
//   uio_out out 8  {6'b0, done, busy}
//   uio_oe  out 8  constant 0 (uio pins are inputs)
module tt_au_booth_multi_hhrb98
  import tt_au_booth_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] X,
  input  logic [7:0] Y,
  output logic [7:0] Z,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t           state;
  acc_t             a_r;
  operand_t         q_r;
  operand_t         m_r;
  logic             q_m1_r;
  logic [CNT_W-1:0] cnt;
  product_t         z_r;
  logic             busy_r;
  logic             done_r;
  logic             start_q;

  acc_t     a_nxt;
  operand_t q_nxt;
  logic     q_m1_nxt;
  logic     start_evt;
  logic     unused_ok;

  // Start is a rising edge of X[4]; a held level launches only one run.
  assign start_evt = X[4] & ~start_q;

  booth_step u_step (
    .a_in     (a_r),
    .q_in     (q_r),
    .q_m1_in  (q_m1_r),
    .m_in     (m_r),
    .a_out    (a_nxt),
    .q_out    (q_nxt),
    .q_m1_out (q_m1_nxt)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      q_r     <= '0;
      m_r     <= '0;
      q_m1_r  <= 1'b0;
      cnt     <= '0;
      z_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      start_q <= 1'b0;
    end else if (ena) begin
      start_q <= X[4];
      case (state)
        IDLE: begin
          if (start_evt) begin
            m_r    <= X[N-1:0];
            q_r    <= Y[N-1:0];
            a_r    <= '0;
            q_m1_r <= 1'b0;
            cnt    <= '0;
            done_r <= 1'b0;
            busy_r <= 1'b1;
            state  <= RUN;
`ifdef BOOTH_CLR_ON_START_EN
            z_r    <= '0;
`else
            z_r    <= z_r;
`endif
          end
        end
        RUN: begin
          a_r    <= a_nxt;
          q_r    <= q_nxt;
          q_m1_r <= q_m1_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(N-1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Product fits in 2N bits, so the top accumulator bit is redundant sign.
          z_r    <= {a_r[N-1:0], q_r};
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign Z       = z_r;
  assign uio_out = {6'b0, done_r, busy_r};
  assign uio_oe  = 8'h00;

  assign unused_ok = &{1'b0, X[7:5], Y[7:4]};

endmodule

// File: tb/tb_tt_au_booth_multi_hhrb98.sv
// tb/tb_tt_au_booth_multi_hhrb98.sv - directed self-checking bench for the Booth multiplier tile
module tb_tt_au_booth_multi_hhrb98;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] X;
  logic [7:0] Y;
  logic [7:0] Z;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_err = 0;

  tt_au_booth_multi_hhrb98 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .X       (X),
    .Y       (Y),
    .Z       (Z),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then wait out the 5-cycle latency and check.
  task automatic mul(input string tag, input logic [3:0] m, input logic [3:0] q,
                     input logic [7:0] exp);
    @(negedge clk);
    X = {3'b000, 1'b1, m};
    Y = {4'h0, q};
    @(posedge clk);
    #1 X[4] = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, uio_out, 8'h01);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check({tag, "_z"}, Z, exp);
    check({tag, "_flags"}, uio_out, 8'h02);
  endtask

  initial begin
    rst_n = 1'b1;
    ena   = 1'b1;
    X     = 8'h00;
    Y     = 8'h00;
    #12;
    check("rst_z", Z, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;

    mul("3x5", 4'h3, 4'h5, 8'h0F);
    mul("m8xm8", 4'h8, 4'h8, 8'h40);
    mul("m3x7", 4'hD, 4'h7, 8'hEB);
    mul("7xm8", 4'h7, 4'h8, 8'hC8);
    mul("m1xm1", 4'hF, 4'hF, 8'h01);

    // Held start level: one computation only (2*3=6).
    @(negedge clk);
    X = 8'h12;
    Y = 8'h03;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("hold_z", Z, 8'h06);
    check("hold_flags", uio_out, 8'h02);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_flags_late", uio_out, 8'h02);
    X = 8'h00;

    // Re-pulse start mid-run with new operands: ignored. Run is 1*-1=-1.
    @(negedge clk);
    X = 8'h11;
    Y = 8'h0F;
    @(posedge clk);
    #1 X[4] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    X = 8'h17;
    Y = 8'h07;
    @(posedge clk);
    @(negedge clk);
`ifdef BOOTH_CLR_ON_START_EN
    check("repulse_z_mid", Z, 8'h00);
`else
    check("repulse_z_mid", Z, 8'h06);
`endif
    check("repulse_busy", uio_out, 8'h01);
    X = 8'h07;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("repulse_z", Z, 8'hFF);
    check("repulse_flags", uio_out, 8'h02);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("repulse_no_queue", uio_out, 8'h02);
    check("repulse_z_hold", Z, 8'hFF);

    // Asynchronous reset in the middle of a run (3*5).
    @(negedge clk);
    X = 8'h13;
    Y = 8'h05;
    @(posedge clk);
    #1 X[4] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("midrst_z", Z, 8'h00);
    check("midrst_uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;

    // Disabled tile ignores a start pulse.
    @(negedge clk);
    ena = 1'b0;
    X   = 8'h13;
    Y   = 8'h05;
    repeat (2) @(posedge clk);
    @(negedge clk);
    X = 8'h03;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("ena0_z", Z, 8'h00);
    check("ena0_uio_out", uio_out, 8'h00);
    check("ena0_uio_oe", uio_oe, 8'h00);
    ena = 1'b1;

    mul("2xm3", 4'h2, 4'hD, 8'hFA);
    check("final_uio_oe", uio_oe, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
